// File: rtl/alu_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_share_sched
// Purpose  : Round-robin scheduler sharing one combinational ALU between NREQ
//            valid/ready requesters; registered result returned per requester.
// Options  : ALU_SCHED_OVF_STICKY_EN adds per-requester sticky overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_sched #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int OPW  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*DW-1:0]   req_a_i,
    input  logic [NREQ*DW-1:0]   req_b_i,
    input  logic [NREQ*OPW-1:0]  req_op_i,
    output logic [DW-1:0]        alu_a_o,
    output logic [DW-1:0]        alu_b_o,
    output logic [OPW-1:0]       alu_opcode_o,
    input  logic [DW-1:0]        alu_out_i,
    input  logic [3:0]           alu_cc_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [DW-1:0]        rsp_data_o,
    output logic [3:0]           rsp_cc_o,
    output logic                 busy_o
`ifdef ALU_SCHED_OVF_STICKY_EN
    ,
    output logic [NREQ-1:0]      ovf_sticky_o,
    input  logic [NREQ-1:0]      ovf_clr_i
`endif
);

    localparam int         c_IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [c_IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [c_IDW-1:0] cur_id_q;
    logic [DW-1:0]    a_q, b_q, rsp_data_q;
    logic [OPW-1:0]   op_q;
    logic [3:0]       rsp_cc_q;

    logic [NREQ-1:0]  w_grant;
    logic [c_IDW-1:0] w_gnt_id;
    logic [c_IDW-1:0] w_idx;
    logic             w_found;
    logic [c_IDW-1:0] w_next_ptr;

    // First valid requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        if (state_q == c_IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = c_IDW'((int'(rr_ptr_q) + k) % NREQ);
                if (!w_found && req_valid_i[w_idx]) begin
                    w_found         = 1'b1;
                    w_grant[w_idx]  = 1'b1;
                    w_gnt_id        = w_idx;
                end
            end
        end
    end

    assign req_ready_o = w_grant;
    assign w_next_ptr  = (cur_id_q == c_IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            c_IDLE: if (w_found) state_d = c_EXEC;
            c_EXEC: state_d = c_RESP;
            c_RESP: begin
                if (rsp_ready_i[cur_id_q]) begin
                    state_d  = c_IDLE;
                    rr_ptr_d = w_next_ptr;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_IDLE;
            rr_ptr_q   <= '0;
            cur_id_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_cc_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (w_found) begin
                cur_id_q <= w_gnt_id;
                a_q      <= req_a_i[w_gnt_id*DW +: DW];
                b_q      <= req_b_i[w_gnt_id*DW +: DW];
                op_q     <= req_op_i[w_gnt_id*OPW +: OPW];
            end
            if (state_q == c_EXEC) begin
                rsp_data_q <= alu_out_i;
                rsp_cc_q   <= alu_cc_i;
            end
        end
    end

    // ALU inputs are forced to zero outside EXEC so it sees no stale operands.
    assign alu_a_o      = (state_q == c_EXEC) ? a_q  : '0;
    assign alu_b_o      = (state_q == c_EXEC) ? b_q  : '0;
    assign alu_opcode_o = (state_q == c_EXEC) ? op_q : '0;

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == c_RESP) rsp_valid_o[cur_id_q] = 1'b1;
    end

    assign rsp_data_o = rsp_data_q;
    assign rsp_cc_o   = rsp_cc_q;
    assign busy_o     = (state_q != c_IDLE);

`ifdef ALU_SCHED_OVF_STICKY_EN
    logic [NREQ-1:0] ovf_q;
    logic [NREQ-1:0] w_ovf_set;

    always_comb begin
        w_ovf_set = '0;
        if ((state_q == c_EXEC) && (alu_cc_i[2] | alu_cc_i[1])) w_ovf_set[cur_id_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= '0;
        else        ovf_q <= (ovf_q & ~ovf_clr_i) | w_ovf_set;
    end

    assign ovf_sticky_o = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_sched
// Purpose  : Randomised + directed bench for alu_share_sched with a queue-based
//            scoreboard and an independent arbitration/ALU reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_sched;
    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int OPW  = 7;
    localparam logic [OPW-1:0] OP_ADD = 7'h00, OP_SUB = 7'h08, OP_AND = 7'h10, OP_OR = 7'h18,
                               OP_XOR = 7'h20, OP_BEQ = 7'h01, OP_J = 7'h02, OP_BAD = 7'h77;

    logic                clk, rst_n;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*DW-1:0]  req_a, req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic [DW-1:0]       alu_a, alu_b, alu_out, rsp_data;
    logic [OPW-1:0]      alu_opcode;
    logic [3:0]          alu_cc, rsp_cc;
    logic                busy;
`ifdef ALU_SCHED_OVF_STICKY_EN
    logic [NREQ-1:0]     ovf_sticky, ovf_clr;
`endif

    alu_share_sched #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_opcode),
        .alu_out_i(alu_out), .alu_cc_i(alu_cc),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_cc_o(rsp_cc), .busy_o(busy)
`ifdef ALU_SCHED_OVF_STICKY_EN
        , .ovf_sticky_o(ovf_sticky), .ovf_clr_i(ovf_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: [2:0]=type (0 R-type, 1 BEQ, 2 J), [6:3]=function.
    function automatic logic [DW+3:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OPW-1:0] op);
        logic [DW-1:0] r;
        logic [3:0]    cc;
        r  = '0;
        cc = '0;
        case (op[2:0])
            3'd0: case (op[6:3])
                4'd0: begin r = a + b; cc[1] = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
                4'd1: begin r = a - b; cc[2] = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
                4'd2: r = a & b;
                4'd3: r = a | b;
                default: r = a ^ b;
            endcase
            3'd1: begin r = a - b; cc[0] = (a == b); end
            3'd2: begin r = a + b; cc[0] = 1'b1; end
            default: r = a ^ ~b;
        endcase
        return {cc, r};
    endfunction

    always_comb {alu_cc, alu_out} = alu_fn(alu_a, alu_b, alu_opcode);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int             id;
        logic [DW-1:0]  a, b, data;
        logic [OPW-1:0] op;
        logic [3:0]     cc;
    } exp_t;

    exp_t          exp_q[$];
    int            grant_log[$];
    logic [DW-1:0] rsp_log[$];
    logic [3:0]    last_cc;
    int            last_id;
    int            n_accept = 0;
    int            n_rsp    = 0;
    int            m_ptr    = 0;
    int            phase    = 0;  // 0 waiting, 1 ALU cycle, 2 response pending
`ifdef ALU_SCHED_OVF_STICKY_EN
    logic [NREQ-1:0] m_ovf = '0;
`endif

    // Monitor / scoreboard: samples mid-cycle, independent of the stimulus flow.
    initial begin
        int              gid;
        logic [NREQ-1:0] exp_g, rv;
        exp_t            e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_rsp_cc", rsp_cc, 0);
                chk("rst_alu_a", alu_a, 0);
                chk("rst_alu_op", alu_opcode, 0);
`ifdef ALU_SCHED_OVF_STICKY_EN
                chk("rst_ovf", ovf_sticky, 0);
                m_ovf = '0;
`endif
                exp_q.delete();
                m_ptr = 0;
                phase = 0;
            end else begin
                gid   = -1;
                exp_g = '0;
                if (phase == 0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        int j;
                        j = (m_ptr + k) % NREQ;
                        if (gid < 0 && req_valid[j]) gid = j;
                    end
                end
                if (gid >= 0) exp_g[gid] = 1'b1;
                chk("req_ready", req_ready, exp_g);
                chk("busy", busy, phase != 0);
                if (phase == 1) begin
                    chk("alu_a", alu_a, exp_q[0].a);
                    chk("alu_b", alu_b, exp_q[0].b);
                    chk("alu_opcode", alu_opcode, exp_q[0].op);
                end else begin
                    chk("alu_a_idle", alu_a, 0);
                    chk("alu_b_idle", alu_b, 0);
                    chk("alu_opcode_idle", alu_opcode, 0);
                end
                if (phase == 2) begin
                    rv = '0;
                    rv[exp_q[0].id] = 1'b1;
                    chk("rsp_valid", rsp_valid, rv);
                    chk("rsp_data", rsp_data, exp_q[0].data);
                    chk("rsp_cc", rsp_cc, exp_q[0].cc);
                end else begin
                    chk("rsp_valid_idle", rsp_valid, 0);
                end
`ifdef ALU_SCHED_OVF_STICKY_EN
                chk("ovf_sticky", ovf_sticky, m_ovf);
                m_ovf = m_ovf & ~ovf_clr;
                if (phase == 1 && (exp_q[0].cc[2] | exp_q[0].cc[1])) m_ovf[exp_q[0].id] = 1'b1;
`endif
                case (phase)
                    0: if (gid >= 0) begin
                        e.id = gid;
                        e.a  = req_a[gid*DW +: DW];
                        e.b  = req_b[gid*DW +: DW];
                        e.op = req_op[gid*OPW +: OPW];
                        {e.cc, e.data} = alu_fn(e.a, e.b, e.op);
                        exp_q.push_back(e);
                        grant_log.push_back(gid);
                        n_accept++;
                        phase = 1;
                    end
                    1: phase = 2;
                    default: if (rsp_ready[exp_q[0].id]) begin
                        rsp_log.push_back(exp_q[0].data);
                        last_cc = exp_q[0].cc;
                        last_id = exp_q[0].id;
                        m_ptr   = (exp_q[0].id + 1) % NREQ;
                        void'(exp_q.pop_front());
                        n_rsp++;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OPW-1:0] op);
        req_a[i*DW +: DW]   = a;
        req_b[i*DW +: DW]   = b;
        req_op[i*OPW +: OPW] = op;
        req_valid[i]        = 1'b1;
    endtask

    task automatic wait_accept(input int prev);
        int t = 0;
        while (n_accept == prev && t < 50) begin tick(); t++; end
        chk("accept_timeout", n_accept != prev, 1);
    endtask

    task automatic wait_rsp(input int target);
        int t = 0;
        while (n_rsp < target && t < 200) begin tick(); t++; end
        chk("rsp_timeout", n_rsp >= target, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [OPW-1:0] op);
        int p, r;
        p = n_accept;
        r = n_rsp;
        set_req(i, a, b, op);
        wait_accept(p);
        req_valid[i] = 1'b0;
        wait_rsp(r + 1);
    endtask

    function automatic logic [DW-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int p, r, g;
        logic [OPW-1:0] ops [8];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_BEQ, OP_J, OP_BAD};
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
`ifdef ALU_SCHED_OVF_STICKY_EN
        ovf_clr = '0;
`endif
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single ADD from requester 0
        rsp_ready = '1;
        run_op(0, 5, 7, OP_ADD);
        chk("t1_data", rsp_log[rsp_log.size()-1], 12);
        chk("t1_cc", last_cc, 0);
        chk("t1_id", last_id, 0);
        chk("t1_busy_low", busy, 0);

        // Contention after reset: strict alternation
        do_reset();
        r = n_rsp; g = grant_log.size();
        set_req(0, 9, 4, OP_SUB);
        set_req(1, 4, 9, OP_SUB);
        wait_rsp(r + 4);
        req_valid = '0;
        for (int k = 0; k < 4; k++) chk("t2_grant_order", grant_log[g+k], k % 2);
        chk("t2_sub_pos", rsp_log[r], 5);
        chk("t2_sub_neg", rsp_log[r+1], 32'hFFFF_FFFB);

        // Backpressure with a competing requester waiting
        rsp_ready = '0;
        r = n_rsp; p = n_accept;
        set_req(0, 100, 23, OP_ADD);
        set_req(1, 1, 2, OP_OR);
        wait_accept(p);
        repeat (6) tick();
        chk("t3_held_rsp", n_rsp, r);
        chk("t3_rsp_valid_held", rsp_valid != 0, 1);
        chk("t3_no_grant", req_ready, 0);
        rsp_ready = '1;
        wait_rsp(r + 1);
        req_valid = '0;
        wait_rsp(n_rsp);

        // Overflow and branch condition codes
        run_op(0, 32'h7FFF_FFFF, 1, OP_ADD);
        chk("t4_ovf_cc", last_cc, 4'b0010);
        run_op(0, 3, 3, OP_BEQ);
        chk("t4_beq_cc0", last_cc[0], 1);
        run_op(0, 10, 20, OP_J);
        chk("t4_j_cc0", last_cc[0], 1);

        // Reset while an op is in the ALU cycle
        p = n_accept;
        set_req(1, 11, 22, OP_ADD);
        wait_accept(p);
        req_valid = '0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        r = n_rsp;
        repeat (4) tick();
        chk("t5_no_rsp", n_rsp, r);
        g = grant_log.size(); p = n_accept;
        set_req(0, 1, 1, OP_XOR);
        set_req(1, 2, 2, OP_XOR);
        wait_accept(p);
        req_valid = '0;
        chk("t5_ptr_zero", grant_log[g], 0);
        wait_rsp(r + 1);

`ifdef ALU_SCHED_OVF_STICKY_EN
        do_reset();
        run_op(1, 32'h7FFF_FFFF, 1, OP_ADD);
        chk("t6_set", ovf_sticky, 2'b10);
        ovf_clr = 2'b10;
        tick();
        ovf_clr = '0;
        chk("t6_clr", ovf_sticky, 2'b00);
        p = n_accept; r = n_rsp;
        set_req(1, 32'h8000_0000, 1, OP_SUB);
        wait_accept(p);
        req_valid = '0;
        ovf_clr = 2'b10;
        tick();
        ovf_clr = '0;
        wait_rsp(r + 1);
        chk("t6_set_wins", ovf_sticky, 2'b10);
`endif

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_a[i*DW +: DW] = rnd_operand();
                req_b[i*DW +: DW] = rnd_operand();
                req_op[i*OPW +: OPW] = ops[$urandom_range(0, 7)];
                rsp_ready[i] = ($urandom_range(0, 9) < 7);
            end
`ifdef ALU_SCHED_OVF_STICKY_EN
            ovf_clr = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
`endif
            tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) tick();
        chk("drain_busy", busy, 0);
        chk("drain_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
